// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM arbiter slice.
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W   = 20;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_WAIT_CYC = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    typedef enum logic {
        REQ_CPU,
        REQ_LDR
    } req_id_t;

endpackage

// File: rtl/sram_arbiter_tristate.sv
// Bidirectional SRAM data-bus driver: drives din onto dout when oe is high.
module tristate
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] dout
);

    assign dout = oe ? din : 'z;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester (CPU / program loader) arbiter for an asynchronous SRAM,
// round-robin on ties, fixed-length access of WAIT_CYC+1 cycles then an ack cycle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data,
    output logic              busy
);

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    req_id_t           gnt, gnt_n;
    req_id_t           last_grant, last_grant_n;
    logic              lat_load, cap_rd;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
    logic              access, drive;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        gnt_n        = gnt;
        last_grant_n = last_grant;
        lat_load     = 1'b0;
        cap_rd       = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req || ldr_req) begin
                    lat_load = 1'b1;
                    cnt_n    = 3'(WAIT_CYC);
                    state_n  = S_ACCESS;
                    if (cpu_req && ldr_req)
                        gnt_n = (last_grant == REQ_CPU) ? REQ_LDR : REQ_CPU;
                    else
                        gnt_n = cpu_req ? REQ_CPU : REQ_LDR;
                end
            end
            S_ACCESS: begin
                if (cnt == 3'd0) begin
                    state_n = S_DONE;
                    cap_rd  = !lat_we;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            S_DONE: begin
                last_grant_n = gnt;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        sel_we    = (gnt_n == REQ_CPU) ? cpu_we    : ldr_we;
        sel_addr  = (gnt_n == REQ_CPU) ? cpu_addr  : ldr_addr;
        sel_wdata = (gnt_n == REQ_CPU) ? cpu_wdata : ldr_wdata;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            gnt         <= REQ_CPU;
            last_grant  <= REQ_LDR;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            gnt        <= gnt_n;
            last_grant <= last_grant_n;
            if (lat_load) begin
                lat_we    <= sel_we;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            if (cap_rd) begin
                if (gnt == REQ_CPU) cpu_rdata_q <= Data;
                else                ldr_rdata_q <= Data;
            end
        end
    end

    // Every output decodes from registered state only, so reset clears them at once.
    assign access    = (state == S_ACCESS);
    assign drive     = access && lat_we;
    assign CE        = !access;
    assign UB        = !access;
    assign LB        = !access;
    assign OE        = !(access && !lat_we);
    assign WE        = !drive;
    assign ADDR      = lat_addr;
    assign busy      = (state != S_IDLE);
    assign cpu_ack   = (state == S_DONE) && (gnt == REQ_CPU);
    assign ldr_ack   = (state == S_DONE) && (gnt == REQ_LDR);
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;

    tristate #(.DATA_W(DATA_W)) u_data_drv (
        .oe  (drive),
        .din (lat_wdata),
        .dout(Data)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, corner-case sequences and a randomized run
// checked against a transaction-level reference model with its own SRAM image.
module tb_sram_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int          W  = 1;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          cpu_req, cpu_we, ldr_req, ldr_we;
    logic [AW-1:0] cpu_addr, ldr_addr;
    logic [DW-1:0] cpu_wdata, ldr_wdata;
    logic [DW-1:0] cpu_rdata, ldr_rdata;
    logic          cpu_ack, ldr_ack, CE, UB, LB, OE, WE, busy;
    logic [AW-1:0] ADDR;
    wire  [DW-1:0] Data;

    // second instance, WAIT_CYC=0, loader writes only
    logic          z_ldr_req, z_ldr_we, z_cpu_req, z_cpu_we;
    logic [AW-1:0] z_ldr_addr, z_cpu_addr;
    logic [DW-1:0] z_ldr_wdata, z_cpu_wdata;
    logic [DW-1:0] z_cpu_rdata, z_ldr_rdata;
    logic          z_cpu_ack, z_ldr_ack, z_CE, z_UB, z_LB, z_OE, z_WE, z_busy;
    logic [AW-1:0] z_ADDR;
    wire  [DW-1:0] z_data;

    always #5 Clk = ~Clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data), .busy(busy)
    );

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(0)) u_dut0 (
        .Clk(Clk), .Reset_n(Reset_n),
        .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
        .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack),
        .ldr_req(z_ldr_req), .ldr_we(z_ldr_we), .ldr_addr(z_ldr_addr), .ldr_wdata(z_ldr_wdata),
        .ldr_rdata(z_ldr_rdata), .ldr_ack(z_ldr_ack),
        .CE(z_CE), .UB(z_UB), .LB(z_LB), .OE(z_OE), .WE(z_WE), .ADDR(z_ADDR), .Data(z_data),
        .busy(z_busy)
    );

    // asynchronous SRAM behavioural model (256 words, low address bits)
    logic [DW-1:0] sram [0:255];
    assign Data = (!CE && !OE) ? sram[ADDR[7:0]] : 'z;
    always @(posedge Clk) if (!CE && !WE) sram[ADDR[7:0]] <= Data;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [DW-1:0] ref_mem [0:255];
    bit            have_txn;
    int            t_start, ecount;
    bit            t_who;        // 0 = cpu, 1 = loader
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    bit            last_who;
    logic [DW-1:0] m_crd, m_lrd;

    task automatic model_reset();
        have_txn = 0; last_who = 1; m_crd = '0; m_lrd = '0; ecount = 0; t_start = 0;
    endtask

    // called just after each rising edge; inputs were stable across the edge
    task automatic model_edge();
        if (!Reset_n) begin
            model_reset();
            return;
        end
        ecount++;
        if (have_txn && ecount >= t_start + W + 3) have_txn = 0;
        if (!have_txn && (cpu_req || ldr_req)) begin
            t_who    = (cpu_req && ldr_req) ? !last_who : ldr_req;
            t_we     = t_who ? ldr_we : cpu_we;
            t_addr   = t_who ? ldr_addr : cpu_addr;
            t_wdata  = t_who ? ldr_wdata : cpu_wdata;
            t_start  = ecount;
            have_txn = 1;
        end
        if (have_txn && ecount == t_start + W + 1) begin
            last_who = t_who;
            if (t_we)       ref_mem[t_addr[7:0]] = t_wdata;
            else if (t_who) m_lrd = ref_mem[t_addr[7:0]];
            else            m_crd = ref_mem[t_addr[7:0]];
        end
    endtask

    task automatic model_check();
        int k;
        bit acc, done;
        k    = ecount - t_start;
        acc  = have_txn && k >= 0 && k <= W;
        done = have_txn && k == W + 1;
        chk("m_ce_ub_lb", {CE, UB, LB}, {3{!acc}});
        chk("m_oe", OE, !(acc && !t_we));
        chk("m_we", WE, !(acc && t_we));
        chk("m_busy", busy, acc || done);
        chk("m_cpu_ack", cpu_ack, done && !t_who);
        chk("m_ldr_ack", ldr_ack, done && t_who);
        chk("m_cpu_rdata", cpu_rdata, m_crd);
        chk("m_ldr_rdata", ldr_rdata, m_lrd);
        if (acc) chk("m_addr", ADDR, t_addr);
        if (acc && t_we) chk("m_wdata", Data, t_wdata);
        if (acc && !t_we) chk("m_rdbus", Data, ref_mem[t_addr[7:0]]);
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            creq, cwe, lreq;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        bit            ce, oe, we, cack, lack, bsy;
        bit            chk_d;
        logic [DW-1:0] d;
        bit            chk_rd;
        logic [DW-1:0] crd, lrd;
    } vec_t;

    vec_t tbl [8];

    int acks_seen, ack_order [4], n_cack, n_lack;

    initial begin
        tbl[0] = '{1, 1, 0, 20'h00010, 16'hBEEF, 0, 1, 0, 0, 0, 1, 1, 16'hBEEF, 0, 16'h0, 16'h0};
        tbl[1] = '{0, 1, 0, 20'h00010, 16'hBEEF, 0, 1, 0, 0, 0, 1, 1, 16'hBEEF, 0, 16'h0, 16'h0};
        tbl[2] = '{0, 0, 0, 20'h00010, 16'h0000, 1, 1, 1, 1, 0, 1, 0, 16'h0,    1, 16'h0, 16'h0};
        tbl[3] = '{0, 0, 0, 20'h00010, 16'h0000, 1, 1, 1, 0, 0, 0, 0, 16'h0,    0, 16'h0, 16'h0};
        tbl[4] = '{1, 0, 0, 20'h00010, 16'h0000, 0, 0, 1, 0, 0, 1, 1, 16'hBEEF, 0, 16'h0, 16'h0};
        tbl[5] = '{0, 0, 0, 20'h00010, 16'h0000, 0, 0, 1, 0, 0, 1, 1, 16'hBEEF, 1, 16'h0, 16'h0};
        tbl[6] = '{0, 0, 0, 20'h00010, 16'h0000, 1, 1, 1, 1, 0, 1, 0, 16'h0,    1, 16'hBEEF, 16'h0};
        tbl[7] = '{0, 0, 0, 20'h00010, 16'h0000, 1, 1, 1, 0, 0, 0, 0, 16'h0,    1, 16'hBEEF, 16'h0};

        for (int i = 0; i < 256; i++) begin
            sram[i]    = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        Reset_n = 1'b0;
        {cpu_req, cpu_we, ldr_req, ldr_we} = '0;
        cpu_addr = '0; ldr_addr = '0; cpu_wdata = '0; ldr_wdata = '0;
        {z_cpu_req, z_cpu_we, z_ldr_req, z_ldr_we} = '0;
        z_cpu_addr = '0; z_ldr_addr = '0; z_cpu_wdata = '0; z_ldr_wdata = '0;
        model_reset();
        repeat (3) step();

        // reset state
        chk("rst_ctrl", {CE, UB, LB, OE, WE}, 5'b11111);
        chk("rst_addr", ADDR, 0);
        chk("rst_acks", {cpu_ack, ldr_ack}, 2'b00);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_busy0", z_busy, 0);
        Reset_n = 1'b1;
        step();

        // WAIT_CYC=0 loader back-to-back writes to 0..3
        z_ldr_req = 1; z_ldr_we = 1; z_ldr_addr = 0; z_ldr_wdata = 16'h1000;
        for (int p = 0; p < 14; p++) begin
            step();
            if (p < 12 && p % 3 == 0) begin
                chk("w0_we", z_WE, 0);
                chk("w0_ce", {z_CE, z_UB, z_LB, z_OE}, 4'b0001);
                chk("w0_addr", z_ADDR, p / 3);
                chk("w0_data", z_data, 16'h1000 + 16'(p / 3));
                chk("w0_ack", {z_ldr_ack, z_cpu_ack}, 2'b00);
                chk("w0_busy", z_busy, 1);
            end else if (p < 12 && p % 3 == 1) begin
                chk("w0_ack_at", z_ldr_ack, 1);
                chk("w0_done_we", z_WE, 1);
                chk("w0_done_busy", z_busy, 1);
                if (p / 3 == 3) z_ldr_req = 0;
                else begin
                    z_ldr_addr  = 20'(p / 3 + 1);
                    z_ldr_wdata = 16'h1000 + 16'(p / 3 + 1);
                end
            end else begin
                chk("w0_idle_busy", z_busy, 0);
                chk("w0_idle_ack", z_ldr_ack, 0);
            end
        end
        chk("w0_rdata", {z_cpu_rdata, z_ldr_rdata}, 0);

        // CPU write 0xBEEF then read back from 0x00010
        for (int i = 0; i < 8; i++) begin
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; ldr_req = tbl[i].lreq;
            cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wd;
            step();
            chk($sformatf("v%0d_ce", i), {CE, UB, LB}, {3{tbl[i].ce}});
            chk($sformatf("v%0d_oe", i), OE, tbl[i].oe);
            chk($sformatf("v%0d_we", i), WE, tbl[i].we);
            chk($sformatf("v%0d_acks", i), {cpu_ack, ldr_ack}, {tbl[i].cack, tbl[i].lack});
            chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
            if (tbl[i].ce == 0) chk($sformatf("v%0d_addr", i), ADDR, tbl[i].addr);
            if (tbl[i].chk_d) chk($sformatf("v%0d_data", i), Data, tbl[i].d);
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), {cpu_rdata, ldr_rdata}, {tbl[i].crd, tbl[i].lrd});
        end

        // cpu_req dropped one cycle after grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00011;
        step();
        chk("drop_busy", busy, 1);
        cpu_req = 0;
        n_cack = 0; n_lack = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            model_check();
            n_cack += int'(cpu_ack);
            n_lack += int'(ldr_ack);
        end
        chk("drop_cack_cnt", n_cack, 1);
        chk("drop_lack_cnt", n_lack, 0);

        // reset in first ACCESS cycle of a write
        cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00020; cpu_wdata = 16'h1234;
        @(posedge Clk);
        model_edge();
        #2;
        chk("ra_we_before", WE, 0);
        Reset_n = 0;
        cpu_req = 0;
        #1;
        model_reset();
        chk("ra_we", WE, 1);
        chk("ra_ce_oe", {CE, OE}, 2'b11);
        chk("ra_busy", busy, 0);
        chk("ra_ack", {cpu_ack, ldr_ack}, 2'b00);
        @(negedge Clk);
        repeat (2) begin
            step();
            chk("ra_ack_rst", {cpu_ack, ldr_ack}, 2'b00);
        end
        Reset_n = 1;
        repeat (4) begin
            step();
            chk("ra_no_ack", {cpu_ack, ldr_ack, busy}, 3'b000);
        end

        // both requesters held: strict alternation, CPU first
        cpu_req = 1; ldr_req = 1; cpu_we = 0; ldr_we = 1;
        cpu_addr = 20'h00010; ldr_addr = 20'h00030; ldr_wdata = 16'h5A5A;
        acks_seen = 0;
        for (int c = 0; c < 40 && acks_seen < 4; c++) begin
            step();
            model_check();
            chk("rr_overlap", {cpu_ack, ldr_ack} == 2'b11, 0);
            if (cpu_ack || ldr_ack) begin
                ack_order[acks_seen] = ldr_ack ? 1 : 0;
                acks_seen++;
            end
        end
        chk("rr_count", acks_seen, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), ack_order[i], i % 2);
        cpu_req = 0; ldr_req = 0;
        repeat (4) begin
            step();
            model_check();
        end

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            cpu_req   = ($urandom_range(0, 2) != 0);
            ldr_req   = ($urandom_range(0, 2) == 0);
            cpu_we    = 1'($urandom);
            ldr_we    = 1'($urandom);
            cpu_addr  = {12'($urandom), 8'($urandom_range(0, 15))};
            ldr_addr  = {12'($urandom), 8'($urandom_range(0, 15))};
            cpu_wdata = 16'($urandom);
            ldr_wdata = 16'($urandom);
            step();
            model_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter WAIT_CYC, default 1, extra SRAM access cycles beyond the first (range 0-7).
REQ-004 Port Clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 Port Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port cpu_req, cpu_we  in  1 each  CPU request and write flag (1 = write).
REQ-007 Port cpu_addr  in  ADDR_W, cpu_wdata  in  DATA_W  CPU address and write data.
REQ-008 Port cpu_rdata  out  DATA_W, cpu_ack  out  1  CPU read data and completion pulse.
REQ-009 Port ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  with the same directions and widths as the cpu_* ports  program-loader/debug requester.
REQ-010 Port CE, UB, LB, OE, WE  out  1 each  active-low SRAM controls.
REQ-011 Port ADDR  out  ADDR_W  SRAM address.
REQ-012 Port Data  inout  DATA_W  SRAM data bus.
REQ-013 Port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states: IDLE, ACCESS, DONE.
REQ-015 IDLE: if any req is high, grant one requester, latch its we/addr/wdata, load wait counter with WAIT_CYC, go to ACCESS; otherwise stay in IDLE.
REQ-016 Both requests high in the same IDLE cycle: grant the requester not granted most recently (round-robin via last_grant flag).
REQ-017 ACCESS: CE=UB=LB=0 and ADDR=latched address; read: OE=0, WE=1; write: WE=0, OE=1, Data driven with latched wdata.
REQ-018 ACCESS lasts exactly WAIT_CYC+1 cycles; counter decrements each cycle; exit to DONE when counter is 0.
REQ-019 Read: capture Data into the granted requester's rdata register on the final ACCESS cycle; the other rdata register holds its value.
REQ-020 DONE: all SRAM controls high, Data high-Z, granted ack=1 for exactly this one cycle, update last_grant, return to IDLE.
REQ-021 Latency: request sampled at IDLE edge n gives ack high during cycle n+WAIT_CYC+2.
REQ-022 A granted transaction is committed; deasserting req before ack does not abort it, and ack still pulses.
REQ-023 A req still high in the IDLE cycle after DONE counts as a new request.
REQ-024 Data is driven only during write ACCESS cycles; in all other states it is high-Z.
REQ-025 The two ack signals are never high in the same cycle.
REQ-026 cpu_req and ldr_req held continuously produce strictly alternating grants.

Reset
REQ-027 While Reset_n=0: state=IDLE, CE=UB=LB=OE=WE=1, ADDR=0, Data high-Z, both acks 0, both rdata 0, busy 0, counter 0, last_grant=loader (CPU wins the first tie).
REQ-028 Reset asserted mid-ACCESS aborts the transaction immediately and asynchronously; no ack is issued for it.

Structure
REQ-029 Package sram_arb_pkg holds the state enum type, the requester-id type (CPU, LDR), and default ADDR_W/DATA_W/WAIT_CYC constants.
REQ-030 The Data bidirectional driver is one instantiated sub-module, tristate, with inputs oe (1 bit) and din (DATA_W) and inout dout.
REQ-031 All outputs are registered or decoded only from registered state, with no combinational path from req inputs to SRAM controls.

Verification
REQ-032 CPU write addr 0x00010, data 0xBEEF, WAIT_CYC=1 -> WE=0 for 2 cycles, Data=0xBEEF, cpu_ack on the 3rd cycle after sampling.
REQ-033 CPU read from 0x00010 with SRAM model holding 0xBEEF -> OE=0 for 2 cycles, cpu_rdata=0xBEEF when cpu_ack=1, ldr_rdata unchanged.
REQ-034 cpu_req and ldr_req asserted together from reset and held -> grant order CPU, LDR, CPU, LDR; acks never overlap.
REQ-035 Reset_n pulled low in the 1st ACCESS cycle of a write -> WE=1 and Data high-Z in the same cycle, no ack, busy=0.
REQ-036 cpu_req dropped one cycle after grant -> transaction completes and cpu_ack still pulses once.
REQ-037 WAIT_CYC=0, back-to-back loader writes to 0x00000-0x00003 -> each ack 2 cycles after its sampling edge, one IDLE cycle between transactions.
